// File: rtl/riscv_div_ctrl_fpga.sv
// riscv_div_ctrl_fpga: multicycle radix-2 restoring divider for EX; define DIV_EARLY_OUT_EN to skip leading dividend zeros
package riscv_defines;
  localparam int ALU_OP_WIDTH = 7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;
endpackage

module riscv_div_ctrl_fpga
  import riscv_defines::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    div_en_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  input  logic                    ex_ready_i,
  output logic [31:0]             result_o,
  output logic                    ready_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_quot, r_div, r_rem;
  logic [5:0]  r_cnt;
  logic        r_neg_q, r_neg_r, r_op_rem;
  logic        w_signed, w_op_rem, w_b_zero, w_ovf, w_special, w_accept, w_bit, w_last;
  logic [31:0] w_abs_a, w_abs_b, w_special_res, w_quot_init, w_q_next, w_rem_next, w_res;
  logic [32:0] w_shift, w_t;
  logic [5:0]  w_cnt_init;

  assign w_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign w_op_rem = (operator_i == ALU_REM) || (operator_i == ALU_REMU);
  assign w_abs_a  = (w_signed && operand_a_i[31]) ? -operand_a_i : operand_a_i;
  assign w_abs_b  = (w_signed && operand_b_i[31]) ? -operand_b_i : operand_b_i;
  assign w_b_zero = operand_b_i == '0;
  assign w_ovf    = w_signed && (operand_a_i == 32'h8000_0000) && (operand_b_i == 32'hFFFF_FFFF);
  // divide-by-zero wins over every other early exit, including a zero dividend
  assign w_special_res = w_b_zero ? (w_op_rem ? operand_a_i : 32'hFFFF_FFFF)
                       : (w_ovf && !w_op_rem) ? 32'h8000_0000 : 32'h0;

`ifdef DIV_EARLY_OUT_EN
  logic [5:0] w_lz;
  always_comb begin
    w_lz = 6'd32;
    for (int i = 0; i < 32; i++) if (w_abs_a[i]) w_lz = 6'(31 - i);
  end
  assign w_special   = w_b_zero || w_ovf || (w_abs_a == '0);
  assign w_quot_init = w_abs_a << w_lz;
  assign w_cnt_init  = 6'd32 - w_lz;
`else
  assign w_special   = w_b_zero || w_ovf;
  assign w_quot_init = w_abs_a;
  assign w_cnt_init  = 6'd32;
`endif

  assign w_accept   = (r_state == S_IDLE) && div_en_i;
  // remainder stays below the divisor, so bit 32 of t is a clean borrow flag
  assign w_shift    = {r_rem, r_quot[31]};
  assign w_t        = w_shift - {1'b0, r_div};
  assign w_bit      = !w_t[32];
  assign w_rem_next = w_bit ? w_t[31:0] : w_shift[31:0];
  assign w_q_next   = {r_quot[30:0], w_bit};
  assign w_last     = r_cnt == 6'd1;
  assign w_res      = r_op_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                               : (r_neg_q ? -w_q_next : w_q_next);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = (r_state == S_IDLE) ? (div_en_i ? (w_special ? S_DONE : S_BUSY) : S_IDLE)
           : (r_state == S_BUSY) ? (!div_en_i ? S_IDLE : (w_last ? S_DONE : S_BUSY))
           : (ex_ready_i ? S_IDLE : S_DONE);
  end

  always_comb begin
    ready_o = ((r_state == S_IDLE) && !div_en_i) || (r_state == S_DONE);
    busy_o  = r_state == S_BUSY;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_quot   <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_op_rem <= 1'b0;
      result_o <= '0;
    end else if (w_accept) begin
      r_op_rem <= w_op_rem;
      r_neg_q  <= w_signed && (operand_a_i[31] ^ operand_b_i[31]);
      r_neg_r  <= w_signed && operand_a_i[31];
      r_quot   <= w_quot_init;
      r_div    <= w_abs_b;
      r_rem    <= '0;
      r_cnt    <= w_cnt_init;
      if (w_special) result_o <= w_special_res;
    end else if ((r_state == S_BUSY) && div_en_i) begin
      r_quot <= w_q_next;
      r_rem  <= w_rem_next;
      r_cnt  <= r_cnt - 6'd1;
      if (w_last) result_o <= w_res;
    end
endmodule

// File: tb/tb_riscv_div_ctrl_fpga.sv
// tb_riscv_div_ctrl_fpga: directed divide vectors checked against an arithmetic reference model
module tb_riscv_div_ctrl_fpga;
  import riscv_defines::*;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, div_en_i = 1'b0, ex_ready_i = 1'b0;
  logic [ALU_OP_WIDTH-1:0] operator_i = ALU_DIVU;
  logic [31:0] operand_a_i = '0, operand_b_i = '0, result_o;
  logic ready_o, busy_o;
  int total = 0, bad = 0;
  int m_left = 0;
  bit m_done = 1'b0;
  logic [31:0] m_res = '0, m_pend = '0;

  riscv_div_ctrl_fpga dut (
    .clk(clk), .rst_n(rst_n), .div_en_i(div_en_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .ex_ready_i(ex_ready_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_sg(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic bit is_ovf(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
    return is_sg(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model_res(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rm = (op == ALU_REM) || (op == ALU_REMU);
    if (b == 0) return rm ? a : 32'hFFFF_FFFF;
    if (is_ovf(op, a, b)) return rm ? 32'h0 : 32'h8000_0000;
    if (is_sg(op)) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? a % b : a / b;
  endfunction

  function automatic int model_iter(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint m;
    if (b == 0 || is_ovf(op, a, b)) return 0;
    if (!EARLY) return 32;
    m = {32'h0, (is_sg(op) && a[31]) ? 32'(-a) : a};
    return $clog2(m + 1);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_done) begin
      if (ex_ready_i) m_done = 1'b0;
    end else if (m_left > 0) begin
      if (!div_en_i) m_left = 0;
      else if (m_left == 1) begin
        m_left = 0;
        m_done = 1'b1;
        m_res  = m_pend;
      end else m_left--;
    end else if (div_en_i) begin
      m_pend = model_res(operator_i, operand_a_i, operand_b_i);
      m_left = model_iter(operator_i, operand_a_i, operand_b_i);
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end

  always @(negedge clk) begin
    chk("cyc_ready", 32'(ready_o), 32'(m_done || (m_left == 0 && !div_en_i)));
    chk("cyc_busy", 32'(busy_o), 32'(m_left > 0));
    chk("cyc_result", result_o, m_res);
  end

  task automatic do_op(input string nm, input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input logic [31:0] lit, input int lat);
    int cyc = 0;
    operator_i = op; operand_a_i = a; operand_b_i = b;
    div_en_i = 1'b1; ex_ready_i = (hold == 0);
    @(negedge clk);
    while (!ready_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(lat));
    chk({nm, "_res"}, result_o, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_rdy"}, 32'(ready_o), 32'd1);
      chk({nm, "_hold_res"}, result_o, lit);
    end
    if (hold > 0) #1 ex_ready_i = 1'b1;
    @(posedge clk); #2;
    div_en_i = 1'b0; ex_ready_i = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_res", result_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdy", 32'(ready_o), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    do_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0, 32'd14, EARLY ? 8 : 33);
    do_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 0, 32'd2, EARLY ? 8 : 33);
    do_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, EARLY ? 4 : 33);
    do_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, EARLY ? 4 : 33);
    do_op("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 0, 32'd1, EARLY ? 4 : 33);
    do_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0", ALU_REM, 32'd5, 32'd0, 0, 32'd5, 1);
    do_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1);
    do_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 1);
    do_op("div_min_2", ALU_DIV, 32'h8000_0000, 32'd2, 0, 32'hC000_0000, 33);
    do_op("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF, 33);
    do_op("divu_1000_3", ALU_DIVU, 32'd1000, 32'd3, 5, 32'd333, EARLY ? 11 : 33);
    do_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 0, 32'd3, EARLY ? 5 : 33);
    operator_i = ALU_DIVU; operand_a_i = 32'hFFFF_0000; operand_b_i = 32'd3; div_en_i = 1'b1;
    repeat (10) begin @(posedge clk); #2; end
    div_en_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("abort_idle", 32'(busy_o), 32'd0);
    chk("abort_rdy", 32'(ready_o), 32'd1);
    chk("abort_res", result_o, 32'd3);
    @(posedge clk); #2;
    div_en_i = 1'b1;
    repeat (5) begin @(posedge clk); #2; end
    rst_n = 1'b0; div_en_i = 1'b0;
    #1;
    chk("rstmid_res", result_o, 32'h0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    do_op("divu_7_2", ALU_DIVU, 32'd7, 32'd2, 0, 32'd3, EARLY ? 4 : 33);
    do_op("divu_0_5", ALU_DIVU, 32'd0, 32'd5, 0, 32'd0, EARLY ? 1 : 33);
    do_op("remu_0_5", ALU_REMU, 32'd0, 32'd5, 0, 32'd0, EARLY ? 1 : 33);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end
endmodule
